// File: rtl/pong_game_fsm.sv
// Match-level Pong controller: keeps the score, sequences idle/serve/play/pause/over
// and times the serve delay on the 1 ms tick.
module pong_game_fsm #(
   parameter int WIN_SCORE   = 5,
   parameter int SERVE_TICKS = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1ms,
   input  logic       start_btn,
   input  logic       pause_btn,
   input  logic       p1_win,
   input  logic       p2_win,
   output logic [2:0] state,
   output logic       game_end,
   output logic       ball_move_en,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [1:0] winner
);

   typedef enum logic [2:0] {
      IDLE     = 3'b000,
      SERVE_P1 = 3'b001,
      SERVE_P2 = 3'b010,
      PLAY     = 3'b011,
      PAUSE    = 3'b111,
      OVER     = 3'b100
   } state_t;

   localparam logic [3:0]  WIN_VAL    = 4'(WIN_SCORE);
   localparam logic [15:0] SERVE_LAST = 16'(SERVE_TICKS - 1);

   state_t      state_q;
   logic        start_prev;
   logic        pause_prev;
   logic [15:0] serve_cnt;
   logic        start_rise;
   logic        pause_rise;
   logic [3:0]  p1_next;
   logic [3:0]  p2_next;

   assign start_rise = start_btn & ~start_prev;
   assign pause_rise = pause_btn & ~pause_prev;
   assign p1_next    = p1_score + 4'd1;
   assign p2_next    = p2_score + 4'd1;

   assign state = state_q;

   // Points are credited only on the edge that leaves PLAY, so a win flag that
   // lingers through the serve can never be counted twice.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         start_prev   <= 1'b0;
         pause_prev   <= 1'b0;
         serve_cnt    <= 16'd0;
         p1_score     <= 4'd0;
         p2_score     <= 4'd0;
         winner       <= 2'b00;
         game_end     <= 1'b0;
         ball_move_en <= 1'b0;
      end else begin
         start_prev <= start_btn;
         pause_prev <= pause_btn;
         case (state_q)
            IDLE: begin
               p1_score <= 4'd0;
               p2_score <= 4'd0;
               winner   <= 2'b00;
               if (start_rise) begin
                  state_q      <= PLAY;
                  ball_move_en <= 1'b1;
               end
            end
            PLAY: begin
               if (p1_win) begin
                  p1_score     <= p1_next;
                  serve_cnt    <= 16'd0;
                  ball_move_en <= 1'b0;
                  if (p1_next == WIN_VAL) begin
                     state_q  <= OVER;
                     winner   <= 2'b01;
                     game_end <= 1'b1;
                  end else begin
                     state_q <= SERVE_P1;
                  end
               end else if (p2_win) begin
                  p2_score     <= p2_next;
                  serve_cnt    <= 16'd0;
                  ball_move_en <= 1'b0;
                  if (p2_next == WIN_VAL) begin
                     state_q  <= OVER;
                     winner   <= 2'b10;
                     game_end <= 1'b1;
                  end else begin
                     state_q <= SERVE_P2;
                  end
               end else if (pause_rise) begin
                  state_q      <= PAUSE;
                  ball_move_en <= 1'b0;
               end
            end
            SERVE_P1, SERVE_P2: begin
               if (tick_1ms) begin
                  if (serve_cnt == SERVE_LAST) begin
                     state_q      <= PLAY;
                     ball_move_en <= 1'b1;
                  end else begin
                     serve_cnt <= serve_cnt + 16'd1;
                  end
               end
            end
            PAUSE: begin
               if (pause_rise) begin
                  state_q      <= PLAY;
                  ball_move_en <= 1'b1;
               end
            end
            OVER: begin
               if (start_rise) begin
                  state_q  <= IDLE;
                  p1_score <= 4'd0;
                  p2_score <= 4'd0;
                  winner   <= 2'b00;
                  game_end <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               game_end     <= 1'b0;
               ball_move_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pong_game_fsm.sv
// Directed bench for pong_game_fsm with WIN_SCORE=5 and a 3-tick serve.
module tb_pong_game_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick_1ms = 1'b0;
   logic       start_btn = 1'b0;
   logic       pause_btn = 1'b0;
   logic       p1_win = 1'b0;
   logic       p2_win = 1'b0;
   logic [2:0] state;
   logic       game_end;
   logic       ball_move_en;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [1:0] winner;

   int n_compared = 0;
   int n_failed   = 0;

   pong_game_fsm #(.WIN_SCORE(5), .SERVE_TICKS(3)) dut (
      .clk(clk),
      .reset(reset),
      .tick_1ms(tick_1ms),
      .start_btn(start_btn),
      .pause_btn(pause_btn),
      .p1_win(p1_win),
      .p2_win(p2_win),
      .state(state),
      .game_end(game_end),
      .ball_move_en(ball_move_en),
      .p1_score(p1_score),
      .p2_score(p2_score),
      .winner(winner)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are read 1 ns after each rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_tick();
      tick_1ms = 1'b1;
      cyc();
      tick_1ms = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      n_compared++;
      if (state !== 3'b000) begin n_failed++; $display("[TB] FAIL reset_state got %b want 000", state); end
      n_compared++;
      if ({game_end, ball_move_en} !== 2'b00) begin n_failed++; $display("[TB] FAIL reset_flags got %b want 00", {game_end, ball_move_en}); end
      n_compared++;
      if ({p1_score, p2_score, winner} !== 10'd0) begin n_failed++; $display("[TB] FAIL reset_score got %h want 0", {p1_score, p2_score, winner}); end
      reset = 1'b0;
      cyc();
      n_compared++;
      if (state !== 3'b000) begin n_failed++; $display("[TB] FAIL idle_hold got %b want 000", state); end
   endtask

   task automatic test_start();
      start_btn = 1'b1;
      cyc();
      n_compared++;
      if (state !== 3'b011) begin n_failed++; $display("[TB] FAIL start_state got %b want 011", state); end
      n_compared++;
      if (ball_move_en !== 1'b1) begin n_failed++; $display("[TB] FAIL start_move got %b want 1", ball_move_en); end
      n_compared++;
      if ({p1_score, p2_score} !== 8'h00) begin n_failed++; $display("[TB] FAIL start_score got %h want 00", {p1_score, p2_score}); end
      start_btn = 1'b0;
      cyc();
   endtask

   task automatic test_point_serve();
      p2_win = 1'b1;
      for (int i = 0; i < 5; i++) cyc();
      p2_win = 1'b0;
      n_compared++;
      if (p2_score !== 4'd1) begin n_failed++; $display("[TB] FAIL point_p2_score got %0d want 1", p2_score); end
      n_compared++;
      if (state !== 3'b010) begin n_failed++; $display("[TB] FAIL point_serve_state got %b want 010", state); end
      n_compared++;
      if (ball_move_en !== 1'b0) begin n_failed++; $display("[TB] FAIL serve_move got %b want 0", ball_move_en); end
      pulse_tick();
      pulse_tick();
      n_compared++;
      if (state !== 3'b010) begin n_failed++; $display("[TB] FAIL serve_early got %b want 010", state); end
      pulse_tick();
      n_compared++;
      if (state !== 3'b011) begin n_failed++; $display("[TB] FAIL serve_done got %b want 011", state); end
   endtask

   // Both win flags, a pause rise and a tick all land in the same PLAY cycle.
   task automatic test_simultaneous();
      p1_win    = 1'b1;
      p2_win    = 1'b1;
      pause_btn = 1'b1;
      tick_1ms  = 1'b1;
      cyc();
      p1_win    = 1'b0;
      p2_win    = 1'b0;
      pause_btn = 1'b0;
      tick_1ms  = 1'b0;
      n_compared++;
      if (state !== 3'b001) begin n_failed++; $display("[TB] FAIL simul_state got %b want 001", state); end
      n_compared++;
      if ({p1_score, p2_score} !== 8'h11) begin n_failed++; $display("[TB] FAIL simul_scores got %h want 11", {p1_score, p2_score}); end
      cyc();
      pulse_tick();
      pulse_tick();
      n_compared++;
      if (state !== 3'b001) begin n_failed++; $display("[TB] FAIL entry_tick got %b want 001", state); end
      pulse_tick();
      n_compared++;
      if (state !== 3'b011) begin n_failed++; $display("[TB] FAIL simul_resume got %b want 011", state); end
   endtask

   task automatic test_pause();
      pause_btn = 1'b1;
      cyc();
      n_compared++;
      if (state !== 3'b111) begin n_failed++; $display("[TB] FAIL pause_state got %b want 111", state); end
      pause_btn = 1'b0;
      p1_win    = 1'b1;
      cyc();
      cyc();
      p1_win = 1'b0;
      n_compared++;
      if (state !== 3'b111) begin n_failed++; $display("[TB] FAIL pause_hold got %b want 111", state); end
      n_compared++;
      if (p1_score !== 4'd1) begin n_failed++; $display("[TB] FAIL pause_score got %0d want 1", p1_score); end
      n_compared++;
      if (ball_move_en !== 1'b0) begin n_failed++; $display("[TB] FAIL pause_move got %b want 0", ball_move_en); end
      pause_btn = 1'b1;
      cyc();
      n_compared++;
      if (state !== 3'b011) begin n_failed++; $display("[TB] FAIL unpause_state got %b want 011", state); end
      n_compared++;
      if (p1_score !== 4'd1) begin n_failed++; $display("[TB] FAIL unpause_score got %0d want 1", p1_score); end
      pause_btn = 1'b0;
      cyc();
   endtask

   // Player 1 starts from 1 point and scores 4 more to reach 5.
   task automatic test_game_over();
      for (int pt = 2; pt <= 5; pt++) begin
         p1_win = 1'b1;
         cyc();
         p1_win = 1'b0;
         n_compared++;
         if (p1_score !== 4'(pt)) begin n_failed++; $display("[TB] FAIL over_p1_score got %0d want %0d", p1_score, pt); end
         if (pt < 5) begin
            n_compared++;
            if (state !== 3'b001) begin n_failed++; $display("[TB] FAIL over_serve got %b want 001", state); end
            pulse_tick();
            pulse_tick();
            pulse_tick();
         end
      end
      n_compared++;
      if (state !== 3'b100) begin n_failed++; $display("[TB] FAIL over_state got %b want 100", state); end
      n_compared++;
      if ({game_end, ball_move_en, winner} !== 4'b1001) begin n_failed++; $display("[TB] FAIL over_flags got %b want 1001", {game_end, ball_move_en, winner}); end
      p2_win    = 1'b1;
      pause_btn = 1'b1;
      cyc();
      p2_win    = 1'b0;
      pause_btn = 1'b0;
      n_compared++;
      if ({state, p2_score} !== {3'b100, 4'd1}) begin n_failed++; $display("[TB] FAIL over_ignore got %b want 1000001", {state, p2_score}); end
      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
      n_compared++;
      if (state !== 3'b000) begin n_failed++; $display("[TB] FAIL restart_state got %b want 000", state); end
      n_compared++;
      if ({p1_score, p2_score, winner, game_end} !== 11'd0) begin n_failed++; $display("[TB] FAIL restart_clear got %h want 0", {p1_score, p2_score, winner, game_end}); end
      cyc();
   endtask

   task automatic test_reset_mid_serve();
      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
      p1_win    = 1'b1;
      cyc();
      p1_win = 1'b0;
      n_compared++;
      if (state !== 3'b001) begin n_failed++; $display("[TB] FAIL midserve_entry got %b want 001", state); end
      pulse_tick();
      pulse_tick();
      reset = 1'b1;
      cyc();
      n_compared++;
      if (state !== 3'b000) begin n_failed++; $display("[TB] FAIL midserve_reset got %b want 000", state); end
      n_compared++;
      if ({p1_score, p2_score, winner, game_end, ball_move_en} !== 12'd0) begin n_failed++; $display("[TB] FAIL midserve_outs got %h want 0", {p1_score, p2_score, winner, game_end, ball_move_en}); end
      reset = 1'b0;
      cyc();
      start_btn = 1'b1;
      cyc();
      start_btn = 1'b0;
      n_compared++;
      if (state !== 3'b011) begin n_failed++; $display("[TB] FAIL midserve_restart got %b want 011", state); end
   endtask

   // Player 2 win path into OVER, checking winner encoding 10.
   task automatic test_p2_wins();
      for (int pt = 1; pt <= 5; pt++) begin
         p2_win = 1'b1;
         cyc();
         p2_win = 1'b0;
         if (pt < 5) begin
            pulse_tick();
            pulse_tick();
            pulse_tick();
         end
      end
      n_compared++;
      if ({state, winner, p2_score} !== {3'b100, 2'b10, 4'd5}) begin n_failed++; $display("[TB] FAIL p2_over got %b want 100100101", {state, winner, p2_score}); end
   endtask

   initial begin
      $display("[TB] starting pong_game_fsm bench");
      cyc();
      test_reset();
      test_start();
      test_point_serve();
      test_simultaneous();
      test_pause();
      test_game_over();
      test_reset_mid_serve();
      test_p2_wins();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
      $finish;
   end

endmodule
